// File: rtl/alu_cmd_issuer_if.sv
// alu_cmd_issuer_if: host command, ALU drive and result signals of alu_cmd_issuer.
// slave = the issuer; master = host, ALU and result consumer.
interface alu_cmd_issuer_if #(
    parameter int DW   = 4,
    parameter int OPW  = 3,
    parameter int CNTW = 8
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [OPW-1:0]  cmd_op;
    logic [DW-1:0]   cmd_a;
    logic [DW-1:0]   cmd_b;
    logic [DW-1:0]   cmd_exp;
    logic [OPW-1:0]  alu_op;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [DW-1:0]   alu_out;
    logic            res_valid;
    logic            res_ready;
    logic [DW-1:0]   res_data;
    logic [OPW-1:0]  res_op;
    logic            res_err;
    logic [CNTW-1:0] mismatch_cnt;
    logic            busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_exp, alu_out, res_ready,
        output cmd_ready, alu_op, alu_a, alu_b, res_valid, res_data, res_op,
               res_err, mismatch_cnt, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_exp, alu_out, res_ready,
        input  cmd_ready, alu_op, alu_a, alu_b, res_valid, res_data, res_op,
               res_err, mismatch_cnt, busy
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: FIFO-buffered command issuer for the combinational ALU with a valid/ready result port.
// Optional ALU_RESULT_CHECK_EN: compare each result with the command's expected value and count mismatches.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  ST_IDLE  | no command in flight; pops the FIFO head into the ALU regs
//  ST_DRIVE | ALU inputs settling for one cycle; result captured at cycle end
//  ST_HOLD  | result presented on res_*, held until res_ready
module alu_cmd_issuer #(
    parameter int DW    = 4,
    parameter int OPW   = 3,
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_cmd_issuer_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_HOLD} state_t;

    state_t          r_state;
    logic [OPW-1:0]  r_mem_op [DEPTH];
    logic [DW-1:0]   r_mem_a  [DEPTH];
    logic [DW-1:0]   r_mem_b  [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_cmd_ready;
    logic [OPW-1:0]  r_alu_op;
    logic [DW-1:0]   r_alu_a;
    logic [DW-1:0]   r_alu_b;
    logic            r_res_valid;
    logic [DW-1:0]   r_res_data;
    logic [OPW-1:0]  r_res_op;
`ifdef ALU_RESULT_CHECK_EN
    logic [DW-1:0]   r_mem_exp [DEPTH];
    logic [DW-1:0]   r_exp;
    logic            r_res_err;
    logic [CNTW-1:0] r_mismatch_cnt;
`endif

    logic            w_push;
    logic            w_pop;
    logic            w_not_empty;
    logic [CW-1:0]   w_count_nxt;

    assign w_not_empty = (r_count != '0);
    assign w_push      = bus.cmd_valid && r_cmd_ready;
    assign w_pop       = w_not_empty &&
                         ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && bus.res_ready));
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    // Storage has no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op[r_wr_ptr] <= bus.cmd_op;
            r_mem_a[r_wr_ptr]  <= bus.cmd_a;
            r_mem_b[r_wr_ptr]  <= bus.cmd_b;
`ifdef ALU_RESULT_CHECK_EN
            r_mem_exp[r_wr_ptr] <= bus.cmd_exp;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cmd_ready <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count     <= w_count_nxt;
            r_cmd_ready <= (w_count_nxt != FULL_CNT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_alu_op    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_op    <= '0;
`ifdef ALU_RESULT_CHECK_EN
            r_exp          <= '0;
            r_res_err      <= 1'b0;
            r_mismatch_cnt <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_alu_op <= r_mem_op[r_rd_ptr];
                        r_alu_a  <= r_mem_a[r_rd_ptr];
                        r_alu_b  <= r_mem_b[r_rd_ptr];
`ifdef ALU_RESULT_CHECK_EN
                        r_exp    <= r_mem_exp[r_rd_ptr];
`endif
                        r_state  <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    r_res_data  <= bus.alu_out;
                    r_res_op    <= r_alu_op;
                    r_res_valid <= 1'b1;
`ifdef ALU_RESULT_CHECK_EN
                    r_res_err   <= (bus.alu_out != r_exp);
                    if ((bus.alu_out != r_exp) && (r_mismatch_cnt != '1))
                        r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
`endif
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        if (w_pop) begin
                            r_alu_op <= r_mem_op[r_rd_ptr];
                            r_alu_a  <= r_mem_a[r_rd_ptr];
                            r_alu_b  <= r_mem_b[r_rd_ptr];
`ifdef ALU_RESULT_CHECK_EN
                            r_exp    <= r_mem_exp[r_rd_ptr];
`endif
                            r_state  <= ST_DRIVE;
                        end else begin
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.alu_op    = r_alu_op;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_op    = r_res_op;
    assign bus.busy      = (r_state != ST_IDLE) || w_not_empty;
`ifdef ALU_RESULT_CHECK_EN
    assign bus.res_err      = r_res_err;
    assign bus.mismatch_cnt = r_mismatch_cnt;
`else
    assign bus.res_err      = 1'b0;
    assign bus.mismatch_cnt = '0;
`endif
endmodule
